mem_access_unit: RTL and testbench

//   Parametrised load/store unit for the multicycle core. Replaces in-FSM byte

---
 rtl/mem_access_unit_if.sv | 41 ++++
 rtl/mem_access_unit.sv | 172 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Bundles the core request/response handshake and the req/gnt/rvalid memory bus
// seen by mem_access_unit; slave is the unit's view, master the surrounding system's.
interface mem_access_unit_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  localparam int BE_W = XLEN / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_fault;
  logic              mem_req;
  logic              mem_gnt;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [BE_W-1:0]   mem_be;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault,
    output mem_req, mem_addr, mem_we, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
    input  mem_req, mem_addr, mem_we, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: one core request -> byte-laned req/gnt/rvalid bus beat(s) -> extended load data.
// Define MISALIGNED_SPLIT_EN to split boundary-crossing accesses into two beats instead of faulting.
module mem_access_unit #(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic              clk,
  input logic              reset,
  mem_access_unit_if.slave bus
);
  localparam int BE_W  = XLEN / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
`ifdef MISALIGNED_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_R, ISSUE2, WAIT_R2, RESP} state_t;
  state_t state, next_state;

  logic              we_q, unsigned_q, split_q, fault_q;
  logic [1:0]        size_q;
  logic [OFF_W-1:0]  off_q;
  logic [ADDR_W-1:0] base_q;
  logic [XLEN-1:0]   wdata_q, beat1_q, rdata_q;
  logic [CNT_W-1:0]  tcnt;

  // Request decode, evaluated on the incoming request while IDLE
  logic [OFF_W-1:0] req_off;
  logic [3:0]       req_n;
  logic [OFF_W:0]   req_mask;
  logic             req_illegal, req_misaligned, req_cross, req_fault;

  assign req_off        = bus.req_addr[OFF_W-1:0];
  assign req_n          = 4'd1 << bus.req_size;
  assign req_mask       = (OFF_W+1)'(req_n) - 1'b1;
  assign req_illegal    = (bus.req_size == 2'd3) && (XLEN == 32);
  assign req_misaligned = |({1'b0, req_off} & req_mask);
  assign req_cross      = (int'(req_off) + int'(req_n)) > BE_W;
  assign req_fault      = req_illegal || (req_misaligned && !SPLIT_EN);

  // Lane placement over a double-width window: low half is beat 1, high half beat 2
  logic [3:0]          n_q;
  logic [2*BE_W-1:0]   be_full;
  logic [2*XLEN-1:0]   wdata_full;
  logic [XLEN-1:0]     rd_lo, rd_hi, rd_shift, mask, load_val;
  logic                sign;

  assign n_q        = 4'd1 << size_q;
  assign be_full    = (((2*BE_W)'(1) << n_q) - 1'b1) << off_q;
  assign wdata_full = {{XLEN{1'b0}}, wdata_q} << {off_q, 3'b000};
  assign rd_lo      = split_q ? beat1_q : bus.mem_rdata;
  assign rd_hi      = split_q ? bus.mem_rdata : '0;
  assign rd_shift   = XLEN'({rd_hi, rd_lo} >> {off_q, 3'b000});

  always_comb begin
    mask = '1;
    sign = rd_shift[XLEN-1];
    case (size_q)
      2'd0:    begin mask = XLEN'(8'hFF);         sign = rd_shift[7];  end
      2'd1:    begin mask = XLEN'(16'hFFFF);      sign = rd_shift[15]; end
      2'd2:    begin mask = XLEN'(32'hFFFF_FFFF); sign = rd_shift[31]; end
      default: ;
    endcase
    load_val = (rd_shift & mask) | ((sign && !unsigned_q) ? ~mask : '0);
  end

  logic waiting, timed_out, timeout_abort, load_done, beat1_done;

  assign waiting   = state inside {ISSUE, WAIT_R, ISSUE2, WAIT_R2};
  assign timed_out = (TIMEOUT_CYCLES != 0) && (tcnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    next_state     = state;
    timeout_abort  = 1'b0;
    load_done      = 1'b0;
    beat1_done     = 1'b0;
    bus.req_ready  = 1'b0;
    bus.rsp_valid  = 1'b0;
    bus.rsp_fault  = 1'b0;
    bus.rsp_rdata  = rdata_q;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_be     = '0;
    bus.mem_wdata  = '0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) next_state = req_fault ? RESP : ISSUE;
      end
      ISSUE: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = we_q;
        bus.mem_addr  = base_q;
        bus.mem_be    = be_full[BE_W-1:0];
        bus.mem_wdata = wdata_full[XLEN-1:0];
        if (bus.mem_gnt)    next_state = we_q ? (split_q ? ISSUE2 : RESP) : WAIT_R;
        else if (timed_out) begin next_state = RESP; timeout_abort = 1'b1; end
      end
      WAIT_R: begin
        if (bus.mem_rvalid) begin
          next_state = split_q ? ISSUE2 : RESP;
          load_done  = !split_q;
          beat1_done = split_q;
        end else if (timed_out) begin next_state = RESP; timeout_abort = 1'b1; end
      end
      ISSUE2: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = we_q;
        bus.mem_addr  = base_q + ADDR_W'(BE_W);
        bus.mem_be    = be_full[2*BE_W-1:BE_W];
        bus.mem_wdata = wdata_full[2*XLEN-1:XLEN];
        if (bus.mem_gnt)    next_state = we_q ? RESP : WAIT_R2;
        else if (timed_out) begin next_state = RESP; timeout_abort = 1'b1; end
      end
      WAIT_R2: begin
        if (bus.mem_rvalid) begin next_state = RESP; load_done = 1'b1; end
        else if (timed_out) begin next_state = RESP; timeout_abort = 1'b1; end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_fault = fault_q;
        next_state    = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q       <= 1'b0;
      unsigned_q <= 1'b0;
      split_q    <= 1'b0;
      fault_q    <= 1'b0;
      size_q     <= '0;
      off_q      <= '0;
      base_q     <= '0;
      wdata_q    <= '0;
      beat1_q    <= '0;
      rdata_q    <= '0;
      tcnt       <= '0;
    end else begin
      // Restarts on every state change, so each ISSUE/WAIT phase gets its own budget
      tcnt <= (waiting && next_state == state) ? tcnt + 1'b1 : '0;
      if (state == IDLE && bus.req_valid) begin
        we_q       <= bus.req_we;
        unsigned_q <= bus.req_unsigned;
        size_q     <= bus.req_size;
        off_q      <= req_off;
        base_q     <= {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        wdata_q    <= bus.req_wdata;
        split_q    <= SPLIT_EN && req_cross;
        fault_q    <= req_fault;
        rdata_q    <= '0;
      end
      if (beat1_done)    beat1_q <= bus.mem_rdata;
      if (load_done)     rdata_q <= load_val;
      if (timeout_abort) fault_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a negedge-driven bus model with wait states and a beat log,
// plus hand-computed vectors for lanes, extension, latency, timeout, split/fault and reset abort.
module tb_mem_access_unit;
  localparam int XLEN = 32;
  localparam int ADDR_W = 32;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } beat_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  mem_access_unit_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

  mem_access_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus model state, shared with the directed test
  logic [31:0] mem_words [logic [31:0]];
  beat_t       beats[$];
  int          stall = 0, r_delay = 1, pend = 0, req_cycles = 0;
  logic        gnt_en = 1'b1, inject_rv = 1'b0, last_rd = 1'b0, hold_valid = 1'b0;
  logic [31:0] last_addr = '0, pend_addr = '0, hold_addr = '0;
  logic [3:0]  hold_be = '0;

  function automatic logic [31:0] read_word(input logic [31:0] a);
    return mem_words.exists(a) ? mem_words[a] : 32'h0;
  endfunction

  always @(negedge clk) begin
    bus.mem_rvalid = 1'b0;
    if (last_rd) begin pend = r_delay; pend_addr = last_addr; end
    last_rd = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin bus.mem_rvalid = 1'b1; bus.mem_rdata = read_word(pend_addr); end
    end
    if (inject_rv) begin bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1234_5678; inject_rv = 1'b0; end
    bus.mem_gnt = 1'b0;
    if (bus.mem_req) begin
      if (hold_valid) begin
        check("req_addr_stable", bus.mem_addr, hold_addr);
        check("req_be_stable", bus.mem_be, hold_be);
      end
      hold_valid = 1'b1; hold_addr = bus.mem_addr; hold_be = bus.mem_be;
      req_cycles++;
      if (stall > 0) stall--;
      else if (gnt_en) begin
        bus.mem_gnt = 1'b1;
        hold_valid  = 1'b0;
        last_rd     = !bus.mem_we;
        last_addr   = bus.mem_addr;
        beats.push_back('{bus.mem_addr, bus.mem_be, bus.mem_wdata, bus.mem_we});
      end
    end else hold_valid = 1'b0;
  end

  // Latency counts the accept cycle as 1 and the rsp_valid cycle inclusively
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic fault);
    beats.delete();
    req_cycles = 0;
    lat = -1; rdata = '0; fault = 1'b0;
    @(negedge clk);
    check("req_ready_idle", bus.req_ready, 1'b1);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
    bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wdata;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int c = 2; c < 40; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin lat = c; rdata = bus.rsp_rdata; fault = bus.rsp_fault; break; end
    end
    if (lat < 0) check("rsp_bound", 1'b0, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    logic [31:0] rd;
    logic flt, seen;

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1'b1);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_fault", bus.rsp_fault, 1'b0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_mem_be", bus.mem_be, 4'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    reset = 1'b0;

    // Aligned word store and load on a zero-wait bus
    do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF, lat, rd, flt);
    check("sw_latency", lat, 3);
    check("sw_beats", beats.size(), 1);
    check("sw_addr", beats[0].addr, 32'h100);
    check("sw_be", beats[0].be, 4'hF);
    check("sw_wdata", beats[0].wdata, 32'hDEAD_BEEF);
    check("sw_we", beats[0].we, 1'b1);
    check("sw_fault", flt, 1'b0);
    check("sw_rdata_zero", rd, 32'h0);
    mem_words[32'h100] = 32'hDEAD_BEEF;
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, lat, rd, flt);
    check("lw_latency", lat, 4);
    check("lw_rdata", rd, 32'hDEAD_BEEF);
    check("lw_we", beats[0].we, 1'b0);

    // Lane selection and extension
    mem_words[32'h100] = 32'h80FF_7F01;
    do_req(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, lat, rd, flt);
    check("lb_103", rd, 32'hFFFF_FF80);
    check("lb_addr_aligned", beats[0].addr, 32'h100);
    check("lb_be", beats[0].be, 4'b1000);
    do_req(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, lat, rd, flt);
    check("lbu_103", rd, 32'h0000_0080);
    do_req(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, lat, rd, flt);
    check("lh_102", rd, 32'hFFFF_80FF);
    do_req(1'b0, 2'd1, 1'b1, 32'h100, 32'h0, lat, rd, flt);
    check("lhu_100", rd, 32'h0000_7F01);
    do_req(1'b1, 2'd0, 1'b0, 32'h101, 32'h0000_00AB, lat, rd, flt);
    check("sb_beats", beats.size(), 1);
    check("sb_be", beats[0].be, 4'b0010);
    check("sb_lane", beats[0].wdata[15:8], 8'hAB);

    // Wait states: gnt low for 5 request cycles, rvalid 3 cycles after gnt
    stall = 5; r_delay = 3;
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, lat, rd, flt);
    check("ws_req_cycles", req_cycles, 6);
    check("ws_latency", lat, 11);
    check("ws_rdata", rd, 32'h80FF_7F01);
    check("ws_fault", flt, 1'b0);
    r_delay = 1;

    // Timeout: gnt never comes
    gnt_en = 1'b0;
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, lat, rd, flt);
    check("to_fault", flt, 1'b1);
    check("to_rdata", rd, 32'h0);
    check("to_latency_window", (lat >= 9 && lat <= 11), 1'b1);
    check("to_mem_req_dropped", bus.mem_req, 1'b0);
    check("to_no_beats", beats.size(), 0);
    gnt_en = 1'b1;
    inject_rv = 1'b1;
    seen = 1'b0;
    repeat (4) begin @(negedge clk); if (bus.rsp_valid) seen = 1'b1; end
    check("to_late_rvalid_ignored", seen, 1'b0);
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, lat, rd, flt);
    check("to_recover_rdata", rd, 32'h80FF_7F01);
    check("to_recover_fault", flt, 1'b0);

    // Illegal size on a 32-bit unit
    do_req(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, lat, rd, flt);
    check("ill_fault", flt, 1'b1);
    check("ill_latency", lat, 2);
    check("ill_no_beats", beats.size(), 0);

    // Boundary-crossing access
    mem_words[32'h0FC] = 32'h1122_3344;
    mem_words[32'h100] = 32'h5566_7788;
`ifdef MISALIGNED_SPLIT_EN
    do_req(1'b0, 2'd2, 1'b0, 32'h0FE, 32'h0, lat, rd, flt);
    check("split_lw_beats", beats.size(), 2);
    check("split_lw_addr1", beats[0].addr, 32'h0FC);
    check("split_lw_be1", beats[0].be, 4'b1100);
    check("split_lw_addr2", beats[1].addr, 32'h100);
    check("split_lw_be2", beats[1].be, 4'b0011);
    check("split_lw_rdata", rd, 32'h7788_1122);
    check("split_lw_fault", flt, 1'b0);
    do_req(1'b1, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'hCAFE_F00D, lat, rd, flt);
    check("split_sw_beats", beats.size(), 2);
    check("split_sw_addr1", beats[0].addr, 32'hFFFF_FFFC);
    check("split_sw_wdata1", {beats[0].wdata[31:16], beats[0].be}, {16'hF00D, 4'b1100});
    check("split_sw_addr2_wrap", beats[1].addr, 32'h0);
    check("split_sw_wdata2", {beats[1].wdata[15:0], beats[1].be}, {16'hCAFE, 4'b0011});
`else
    do_req(1'b0, 2'd2, 1'b0, 32'h0FE, 32'h0, lat, rd, flt);
    check("mis_fault", flt, 1'b1);
    check("mis_latency", lat, 2);
    check("mis_no_mem_req", req_cycles, 0);
    check("mis_rdata", rd, 32'h0);
`endif

    // Reset while waiting for read data
    mem_words[32'h100] = 32'hA5A5_0F0F;
    r_delay = 6;
    beats.delete();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h100;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_busy", bus.req_ready, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_mem_req", bus.mem_req, 1'b0);
    check("rst_mid_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_mid_ready", bus.req_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (bus.rsp_valid) seen = 1'b1; end
    check("rst_mid_no_rsp", seen, 1'b0);
    r_delay = 1;
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, lat, rd, flt);
    check("rst_fresh_latency", lat, 4);
    check("rst_fresh_rdata", rd, 32'hA5A5_0F0F);
    check("rst_fresh_fault", flt, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
